uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage: the far-end counterpart of the board's UART transmitter, consuming the 8N1 serial stream it produces.
- Recovers each byte by mid-bit sampling and presents it to the core/MMIO layer through a ready/valid holding register.
- Flags framing errors and overruns as single-cycle pulses for status counters.

Parameters:
- CLOCK_FREQ, 125_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line rate in bit/s. Derived: SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (cycles per bit); SAMPLE_TIME = SYMBOL_EDGE_TIME/2. Counter width = $clog2(SYMBOL_EDGE_TIME)+1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- serial_in  in  1  asynchronous UART line; idles high.
- data_out  out  8  received byte; valid only while data_out_valid=1.
- data_out_valid  out  1  holding register full.
- data_out_ready  in  1  consumer accepts data_out when high with valid.
- framing_error  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while holding register full.

Behaviour:
- Reset: synchronizer flops=1, state=IDLE, counter=0, shift reg=0, data_out=0, data_out_valid=0, framing_error=0, overrun=0. Reset mid-frame abandons the frame with no output and no pulses.
- Sync: serial_in passes two flops (rx_s); only rx_s is used.
- IDLE: rx_s=0 -> START, counter=0.
- START: counter increments each cycle; at counter==SAMPLE_TIME-1 sample rx_s. 0 -> DATA, counter=0, bit_idx=0. 1 -> glitch, back to IDLE, no pulse.
- DATA: at counter==SYMBOL_EDGE_TIME-1 sample rx_s into shift reg LSB-first (bit_idx 0 = data_out[0]), counter=0, bit_idx++. After 8th sample -> STOP.
- STOP: at counter==SYMBOL_EDGE_TIME-1 sample rx_s.
  - 1 and holding register free (valid=0, or valid&ready this cycle) -> load data_out, valid=1 next cycle, state -> IDLE.
  - 1 and register full and not draining -> byte dropped, data_out unchanged, overrun=1 for one cycle, state -> IDLE.
  - 0 -> byte dropped, framing_error=1 for one cycle, state -> WAIT_IDLE.
- WAIT_IDLE: remain until rx_s=1, then IDLE. This covers breaks and prevents a false start on a held-low line.
- Holding register:
  - valid&ready clears valid next cycle unless a new byte loads the same cycle; in that case valid stays 1 and data_out takes the new byte.
  - data_out stays stable while valid=1 and ready=0.
- Latency: the pin falling edge aligned to a clk edge at cycle 0 gives valid=1 at cycle 3 + SAMPLE_TIME + 9*SYMBOL_EDGE_TIME, ±1 allowed for edge alignment.
- Back-to-back frames: a new start bit is accepted on the first IDLE cycle after stop sampling, with no added gap required.
- Receiver operation is independent of consumer state. Only overrun reports loss.

Test Plan (CLOCK_FREQ=1000, BAUD_RATE=100 → 10 cycles/bit, SAMPLE_TIME=5):
- Single byte: drive 0xA5 8N1 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), ready=1 -> data_out=0xA5, valid high for one cycle at 3+5+90=98±1 cycles after start edge, no error pulses.
- Backpressure/overrun: ready=0, send 0x3C then 0x7E back-to-back -> data_out=0x3C held through the second frame, overrun pulses once at 0x7E stop sample. Then ready=1 -> valid drops, data_out stays 0x3C.
- Simultaneous drain+load: ready=0, send 0x11, raise ready exactly on the cycle 0x22 completes -> valid stays 1, data_out=0x22, no overrun.
- Framing error: send 0x55 with stop bit 0, hold line low 40 cycles, then high -> framing_error one pulse, valid stays 0, no start detected until line returns high; following 0x0F frame received correctly.
- Glitch: 3-cycle low pulse on idle line -> back to IDLE after the START sample at cycle 5, no valid, no pulses.
- Reset mid-frame: assert reset during DATA bit 4 of 0xFF, release, send 0x81 -> only 0x81 is delivered, all outputs 0 during reset.

Source files
------------

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling and a ready/valid holding register
// Framing errors and overruns are reported as single-cycle pulses.
module uart_receiver #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME) + 1;
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);
  localparam logic [CW-1:0] SYMBOL_LAST = CW'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state_q;
  logic          rx_meta_q;
  logic          rx_s_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          fe_q;
  logic          ov_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      rx_meta_q <= serial_in;
      rx_s_q    <= rx_meta_q;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      // A drain is overridden below when a new byte loads in the same cycle.
      if (valid_q && data_out_ready) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == SAMPLE_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= IDLE;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == SYMBOL_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == SYMBOL_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= IDLE;
              if (!valid_q || data_out_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ov_q <= 1'b1;
              end
            end else begin
              fe_q    <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // Hold here through a break so a held-low line is not taken as a start bit.
          if (rx_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign framing_error  = fe_q;
  assign overrun        = ov_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized self-checking bench for uart_receiver
// Frames are generated bit-serially; expected bytes and pulses come from a frame-level model.
module tb_uart_receiver;

  localparam int CLOCK_FREQ = 1000;
  localparam int BAUD_RATE  = 100;
  localparam int BIT        = CLOCK_FREQ / BAUD_RATE;

  logic       clk;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       prev_v, prev_r;
  logic [7:0] prev_d;

  uart_receiver #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk            (clk),
    .reset          (reset),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .framing_error  (framing_error),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consumer-side monitor: accepted bytes, pulse counts, and hold stability under backpressure.
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (data_out_valid && data_out_ready) got_q.push_back(data_out);
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (prev_v && !prev_r && data_out_valid) check("hold_stable", {24'd0, data_out}, {24'd0, prev_d});
      prev_v = data_out_valid;
    end
    prev_r = data_out_ready;
    prev_d = data_out;
  end

  task automatic clr();
    got_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_in = f[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"}, {24'd0, data_out}, 32'd0);
    check({tag, "_valid"}, {31'd0, data_out_valid}, 32'd0);
    check({tag, "_fe"}, {31'd0, framing_error}, 32'd0);
    check({tag, "_ov"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  seen;
    int  fe_exp;
    logic [7:0] b;
    bit  bad;

    reset = 1'b1;
    serial_in = 1'b1;
    data_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    idle(10);

    // Single byte with latency measurement.
    clr();
    lat = 0;
    seen = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (lat < 200 && !seen) begin
          @(posedge clk);
          lat++;
          #1;
          if (data_out_valid) seen = 1;
        end
        check("a5_seen", {31'd0, seen}, 32'd1);
        check("a5_latency_in_97_99", {31'd0, (lat >= 97 && lat <= 99)}, 32'd1);
        check("a5_data", {24'd0, data_out}, 32'hA5);
        @(posedge clk);
        #1;
        check("a5_valid_one_cycle", {31'd0, data_out_valid}, 32'd0);
      end
    join
    idle(5);
    check("a5_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) check("a5_got", {24'd0, got_q[0]}, 32'hA5);
    check("a5_fe", fe_cnt, 32'd0);
    check("a5_ov", ov_cnt, 32'd0);

    // Backpressure with overrun on the second frame.
    clr();
    data_out_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    send_frame(8'h7E, 1'b1);
    idle(3);
    check("bp_valid", {31'd0, data_out_valid}, 32'd1);
    check("bp_data", {24'd0, data_out}, 32'h3C);
    check("bp_ov_once", ov_cnt, 32'd1);
    data_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_drained", {31'd0, data_out_valid}, 32'd0);
    check("bp_data_kept", {24'd0, data_out}, 32'h3C);
    idle(5);
    check("bp_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) check("bp_got", {24'd0, got_q[0]}, 32'h3C);

    // Drain and load on the same cycle.
    clr();
    data_out_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle(5);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (97) @(posedge clk);
        #1;
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        data_out_ready = 1'b0;
        check("dl_valid_held", {31'd0, data_out_valid}, 32'd1);
        check("dl_data_new", {24'd0, data_out}, 32'h22);
      end
    join
    check("dl_ov", ov_cnt, 32'd0);
    check("dl_count_first", got_q.size(), 32'd1);
    if (got_q.size() > 0) check("dl_got_first", {24'd0, got_q[0]}, 32'h11);
    data_out_ready = 1'b1;
    idle(5);
    check("dl_count", got_q.size(), 32'd2);
    if (got_q.size() > 1) check("dl_got_second", {24'd0, got_q[1]}, 32'h22);

    // Framing error followed by a held-low line.
    clr();
    send_frame(8'h55, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    idle(20);
    check("fe_once", fe_cnt, 32'd1);
    check("fe_no_byte", got_q.size(), 32'd0);
    check("fe_valid", {31'd0, data_out_valid}, 32'd0);
    send_frame(8'h0F, 1'b1);
    idle(5);
    check("fe_next_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) check("fe_next_got", {24'd0, got_q[0]}, 32'h0F);
    check("fe_next_fe", fe_cnt, 32'd1);

    // Short glitch on the idle line.
    clr();
    serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(30);
    check("gl_no_byte", got_q.size(), 32'd0);
    check("gl_fe", fe_cnt, 32'd0);
    check("gl_ov", ov_cnt, 32'd0);

    // Reset in the middle of a frame.
    clr();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (55) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("rst_mid");
        reset = 1'b0;
      end
    join
    idle(20);
    send_frame(8'h81, 1'b1);
    idle(5);
    check("rst_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) check("rst_got", {24'd0, got_q[0]}, 32'h81);
    check("rst_fe", fe_cnt, 32'd0);
    check("rst_ov", ov_cnt, 32'd0);

    // Randomized frames against the frame-level model.
    clr();
    exp_q.delete();
    fe_exp = 0;
    data_out_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      send_frame(b, !bad);
      if (bad) fe_exp++;
      else exp_q.push_back(b);
      idle(bad ? $urandom_range(3, 12) : $urandom_range(0, 12));
    end
    idle(20);
    check("rnd_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("rnd_byte%0d", k), {24'd0, got_q[k]}, {24'd0, exp_q[k]});
    check("rnd_fe", fe_cnt, fe_exp);
    check("rnd_ov", ov_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
